// File: rtl/imem_loader_if.sv
// Bundles the boot-byte stream, load control and instruction-memory write port.
// slave is the loader's view; master is the host/boot-source view.
interface imem_loader_if #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32
);
    logic                      START;
    logic [ADDR_WIDTH-1:0]     BASE_ADDR;
    logic [ADDR_WIDTH-1:0]     LEN;
    logic [7:0]                DIN;
    logic                      DIN_VALID;
    logic                      DIN_READY;
    logic                      WE;
    logic [ADDR_WIDTH-1:0]     WA;
    logic [BYTE_SIZE*8-1:0]    WD;
    logic [BYTE_SIZE-1:0]      BYTE_EN;
    logic                      BUSY;
    logic                      CPU_HOLD;
    logic                      DONE;
    logic                      ERR;

    modport master (
        output START, BASE_ADDR, LEN, DIN, DIN_VALID,
        input  DIN_READY, WE, WA, WD, BYTE_EN, BUSY, CPU_HOLD, DONE, ERR
    );

    modport slave (
        input  START, BASE_ADDR, LEN, DIN, DIN_VALID,
        output DIN_READY, WE, WA, WD, BYTE_EN, BUSY, CPU_HOLD, DONE, ERR
    );
endinterface

// File: rtl/imem_loader.sv
// Packs an 8-bit boot stream into little-endian words and writes them into the
// instruction memory, holding the processor off while the load runs.
module imem_loader #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 24
) (
    input logic          CLK,
    input logic          RESET,
    imem_loader_if.slave bus
);
    localparam int DATA_W = BYTE_SIZE * 8;
    localparam int LANE_W = $clog2(BYTE_SIZE + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] FIN     = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(BYTE_SIZE);
    localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);
    localparam logic [LANE_W-1:0]     LANE_ONE  = LANE_W'(1);
    localparam logic [LANE_W-1:0]     LANE_FULL = LANE_W'(BYTE_SIZE);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] count;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [LANE_W-1:0]     lane;
    logic [DATA_W-1:0]     word_buf;
    logic [BYTE_SIZE-1:0]  fill_be;
    logic [DATA_W-1:0]     buf_next;
    logic [BYTE_SIZE-1:0]  be_next;
    logic [ADDR_WIDTH-1:0] wa_q;
    logic [DATA_W-1:0]     wd_q;
    logic [BYTE_SIZE-1:0]  be_q;
    logic                  we_q;
    logic                  done_q;
    logic                  err_q;
    logic                  accept;
    logic                  word_full;
    logic                  last_byte;
    logic                  misaligned;
    logic                  out_of_range;
    logic [ADDR_WIDTH:0]   end_addr;

    // Merge the incoming byte into its lane; the extra-wide sum keeps the range check from wrapping.
    always_comb begin
        buf_next = word_buf;
        be_next  = fill_be;
        for (int k = 0; k < BYTE_SIZE; k++) begin
            if (lane == LANE_W'(k)) begin
                buf_next[8*k +: 8] = bus.DIN;
                be_next[k]         = 1'b1;
            end
        end
        accept       = (state == COLLECT) && bus.DIN_VALID;
        word_full    = (lane + LANE_ONE) == LANE_FULL;
        last_byte    = (count + ONE_A) == len_q;
        end_addr     = {1'b0, bus.BASE_ADDR} + {1'b0, bus.LEN};
        misaligned   = (bus.BASE_ADDR % WORD_STEP) != '0;
        out_of_range = end_addr > MEM_LIMIT;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            len_q     <= '0;
            count     <= '0;
            word_addr <= '0;
            lane      <= '0;
            word_buf  <= '0;
            fill_be   <= '0;
            wa_q      <= '0;
            wd_q      <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (bus.START) begin
                        len_q     <= bus.LEN;
                        word_addr <= bus.BASE_ADDR;
                        count     <= '0;
                        lane      <= '0;
                        word_buf  <= '0;
                        fill_be   <= '0;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        if (misaligned || out_of_range) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= FIN;
                        end else if (bus.LEN == '0) begin
                            done_q <= 1'b1;
                            state  <= FIN;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        word_buf <= buf_next;
                        fill_be  <= be_next;
                        lane     <= lane + LANE_ONE;
                        count    <= count + ONE_A;
                        // Launch the write straight from the merged word so WE lands one cycle later.
                        if (word_full || last_byte) begin
                            state <= WRITE;
                            we_q  <= 1'b1;
                            wa_q  <= word_addr;
                            wd_q  <= buf_next;
                            be_q  <= be_next;
                        end
                    end
                end
                WRITE: begin
                    word_buf  <= '0;
                    fill_be   <= '0;
                    lane      <= '0;
                    word_addr <= word_addr + WORD_STEP;
                    if (count == len_q) begin
                        state  <= FIN;
                        done_q <= 1'b1;
                    end else begin
                        state <= COLLECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.DIN_READY = (state == COLLECT);
    assign bus.BUSY      = (state == COLLECT) || (state == WRITE);
    assign bus.CPU_HOLD  = bus.BUSY;
    assign bus.WE        = we_q;
    assign bus.WA        = wa_q;
    assign bus.WD        = wd_q;
    assign bus.BYTE_EN   = be_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, a reset-mid-load sequence
// and random loads compared against a word-packing reference model.
module tb_imem_loader;
    localparam int BS = 4;
    localparam int AW = 32;
    localparam int MB = 24;

    typedef struct {
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  be;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] len;
        int          mode;
        logic [7:0]  first;
        logic [7:0]  step;
        logic        exp_err;
        int          exp_writes;
        logic [31:0] exp_wa_last;
        logic [31:0] exp_wd_last;
        logic [3:0]  exp_be_last;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET;
    int   cycle = 0;
    int   errors = 0;
    int   checks = 0;
    bit   ready_seen;
    bit   ready_in_write;
    wr_t  exp_q[$];
    wr_t  got_q[$];
    logic [7:0] stream_bytes [0:31];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle <= cycle + 1;

    imem_loader_if #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW)) bus ();

    imem_loader #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW), .MEM_BYTES(MB)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    // Capture every write and watch the ready line between edges.
    always @(negedge CLK) begin
        if (bus.DIN_READY) ready_seen = 1'b1;
        if (bus.WE) begin
            if (bus.DIN_READY) ready_in_write = 1'b1;
            got_q.push_back('{bus.WA, bus.WD, bus.BYTE_EN, cycle});
        end
    end

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " din_ready"}, bus.DIN_READY, 0);
        check_output({tag, " we"},        bus.WE, 0);
        check_output({tag, " busy"},      bus.BUSY, 0);
        check_output({tag, " cpu_hold"},  bus.CPU_HOLD, 0);
        check_output({tag, " done"},      bus.DONE, 0);
        check_output({tag, " err"},       bus.ERR, 0);
        check_output({tag, " wa"},        bus.WA, 0);
        check_output({tag, " wd"},        bus.WD, 0);
        check_output({tag, " byte_en"},   bus.BYTE_EN, 0);
    endtask

    task automatic fill_stream(input logic [7:0] first, input logic [7:0] step);
        for (int i = 0; i < 32; i++) stream_bytes[i] = 8'(first + 8'(i) * step);
    endtask

    // mode 0: VALID always high, 1: VALID toggles, 2: VALID random.
    task automatic apply_stimulus(input logic [31:0] base, input logic [31:0] len, input int mode);
        int   idx;
        int   waited;
        int   s;
        int   t;
        int   lane;
        bit   model_err;
        logic hs;
        wr_t  cur;

        @(negedge CLK);
        got_q.delete();
        exp_q.delete();
        ready_seen     = 1'b0;
        ready_in_write = 1'b0;
        s              = cycle + 1;
        bus.START      = 1'b1;
        bus.BASE_ADDR  = base;
        bus.LEN        = len;
        bus.DIN_VALID  = 1'b0;

        // Reference: every LEN bytes fill words lane by lane from the base address.
        model_err = ((base % 4) != 0) || ((longint'(base) + longint'(len)) > MB);
        cur = '{32'd0, 32'd0, 4'd0, 0};
        t   = s;
        if (!model_err) begin
            for (int b = 0; b < int'(len); b++) begin
                lane = b % 4;
                if (lane == 0) cur = '{base + 32'(4 * (b / 4)), 32'd0, 4'd0, 0};
                cur.wd[8*lane +: 8] = stream_bytes[b];
                cur.be[lane]        = 1'b1;
                if (lane == 3 || b == int'(len) - 1) begin
                    t       = (exp_q.size() == 0) ? s + lane + 1 : t + 1 + lane + 1;
                    cur.cyc = t;
                    exp_q.push_back(cur);
                end
            end
        end

        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
        waited    = 1;
        idx       = 0;
        while (!bus.DONE && waited < 300) begin
            if (idx < int'(len)) begin
                case (mode)
                    0:       bus.DIN_VALID = 1'b1;
                    1:       bus.DIN_VALID = waited[0];
                    default: bus.DIN_VALID = 1'($urandom_range(0, 1));
                endcase
                bus.DIN = bus.DIN_VALID ? stream_bytes[idx] : 8'($urandom);
            end else begin
                bus.DIN_VALID = 1'b0;
            end
            hs = bus.DIN_VALID && bus.DIN_READY;
            @(posedge CLK);
            if (hs) idx++;
            @(negedge CLK);
            waited++;
        end
        bus.DIN_VALID = 1'b0;

        check_output("done", bus.DONE, 1);
        check_output("err", bus.ERR, model_err);
        check_output("busy", bus.BUSY, 0);
        check_output("cpu_hold", bus.CPU_HOLD, 0);
        check_output("write_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_output("wa", got_q[i].wa, exp_q[i].wa);
            check_output("wd", got_q[i].wd, exp_q[i].wd);
            check_output("byte_en", got_q[i].be, exp_q[i].be);
            if (mode == 0) check_output("we_cycle", got_q[i].cyc, exp_q[i].cyc);
        end
        check_output("ready_seen", ready_seen, exp_q.size() > 0);
        check_output("ready_in_write", ready_in_write, 0);
        if (exp_q.size() == 0) check_output("done_latency", waited, 1);
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] rb;
        logic [31:0] rl;

        vecs[0] = '{32'd0,  32'd8,  0, 8'h01, 8'h01, 1'b0, 2, 32'd4,  32'h08070605, 4'hF};
        vecs[1] = '{32'd4,  32'd6,  0, 8'hAA, 8'h11, 1'b0, 2, 32'd8,  32'h0000FFEE, 4'h3};
        vecs[2] = '{32'd20, 32'd8,  0, 8'h01, 8'h01, 1'b1, 0, 32'd0,  32'h0,        4'h0};
        vecs[3] = '{32'd2,  32'd4,  0, 8'h01, 8'h01, 1'b1, 0, 32'd0,  32'h0,        4'h0};
        vecs[4] = '{32'd0,  32'd0,  0, 8'h01, 8'h01, 1'b0, 0, 32'd0,  32'h0,        4'h0};
        vecs[5] = '{32'd8,  32'd4,  1, 8'h10, 8'h01, 1'b0, 1, 32'd8,  32'h13121110, 4'hF};
        vecs[6] = '{32'd0,  32'd24, 0, 8'h20, 8'h01, 1'b0, 6, 32'd20, 32'h37363534, 4'hF};
        vecs[7] = '{32'd16, 32'd9,  0, 8'h01, 8'h01, 1'b1, 0, 32'd0,  32'h0,        4'h0};

        RESET         = 1'b1;
        bus.START     = 1'b0;
        bus.BASE_ADDR = '0;
        bus.LEN       = '0;
        bus.DIN       = '0;
        bus.DIN_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_all_zero("reset");
        RESET = 1'b0;

        for (int v = 0; v < 8; v++) begin
            fill_stream(vecs[v].first, vecs[v].step);
            apply_stimulus(vecs[v].base, vecs[v].len, vecs[v].mode);
            check_output("vec_err", bus.ERR, vecs[v].exp_err);
            check_output("vec_writes", got_q.size(), vecs[v].exp_writes);
            if (vecs[v].exp_writes > 0 && got_q.size() > 0) begin
                check_output("vec_wa_last", got_q[got_q.size()-1].wa, vecs[v].exp_wa_last);
                check_output("vec_wd_last", got_q[got_q.size()-1].wd, vecs[v].exp_wd_last);
                check_output("vec_be_last", got_q[got_q.size()-1].be, vecs[v].exp_be_last);
            end
        end

        // Reset after three bytes of a load must drop the partial word entirely.
        fill_stream(8'h51, 8'h01);
        apply_stimulus(32'd0, 32'd4, 0);
        @(negedge CLK);
        bus.START     = 1'b1;
        bus.BASE_ADDR = 32'd0;
        bus.LEN       = 32'd8;
        @(posedge CLK);
        @(negedge CLK);
        bus.START     = 1'b0;
        bus.DIN_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.DIN = stream_bytes[k];
            @(posedge CLK);
            @(negedge CLK);
        end
        got_q.delete();
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_all_zero("mid_reset");
        RESET      = 1'b0;
        ready_seen = 1'b0;
        repeat (6) @(negedge CLK);
        bus.DIN_VALID = 1'b0;
        check_output("post_reset_we", got_q.size(), 0);
        check_output("post_reset_ready", ready_seen, 0);
        fill_stream(8'hC1, 8'h01);
        apply_stimulus(32'd0, 32'd4, 0);

        for (int r = 0; r < 25; r++) begin
            rb = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 23)) : 32'(4 * $urandom_range(0, 5));
            rl = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 26)) : 32'($urandom_range(0, 24 - rb));
            for (int i = 0; i < 32; i++) stream_bytes[i] = 8'($urandom);
            apply_stimulus(rb, rl, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side companion to the byte-addressed, little-endian instruction memory.
- Accepts a program as an 8-bit byte stream over a valid/ready handshake and assembles bytes into BYTE_SIZE-byte words.
- Issues one registered word-write per word into the instruction memory's write port.
- Holds the processor pipeline off while loading; sits between the host/boot byte source and the instruction memory.

Parameters:
- BYTE_SIZE, 4: bytes per word; write data width is BYTE_SIZE*8.
- ADDR_WIDTH, 32: byte-address width.
- MEM_BYTES, 24: capacity of the target memory in bytes; used for the range check.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  begin load; sampled only in IDLE or DONE.
- BASE_ADDR  input  ADDR_WIDTH  first byte address; sampled with START.
- LEN  input  ADDR_WIDTH  byte count to load; sampled with START.
- DIN  input  8  stream byte.
- DIN_VALID  input  1  DIN holds a valid byte.
- DIN_READY  output  1  loader accepts a byte this cycle.
- WE  output  1  write strobe to instruction memory, one cycle per word.
- WA  output  ADDR_WIDTH  word-aligned byte address of the write.
- WD  output  BYTE_SIZE*8  write word; byte k on bits [8k+:8].
- BYTE_EN  output  BYTE_SIZE  lane enables for the write.
- BUSY  output  1  load in progress.
- CPU_HOLD  output  1  stall request to processor; equals BUSY.
- DONE  output  1  load finished (level).
- ERR  output  1  last START rejected.

Behaviour:
- Reset values: DIN_READY, WE, BUSY, CPU_HOLD, DONE, ERR = 0; WA, WD, BYTE_EN = 0. State returns to IDLE.
- Reset mid-load discards the partial word and issues no further WE.
- States: IDLE, COLLECT, WRITE, FIN.
- IDLE/FIN, START=1: latch BASE_ADDR and LEN; clear the byte counter, lane index and word buffer; clear DONE and ERR.
  - If BASE_ADDR % BYTE_SIZE != 0, or BASE_ADDR+LEN > MEM_BYTES (computed ADDR_WIDTH+1 wide, no wrap): ERR=1, DONE=1, go to FIN with no writes.
  - Else if LEN==0: DONE=1, go to FIN with no writes.
  - Else: go to COLLECT, BUSY=1.
- START in COLLECT or WRITE is ignored.
- COLLECT:
  - DIN_READY=1.
  - On DIN_VALID&&DIN_READY: store DIN in lane `lane`, set its BYTE_EN bit, increment lane and byte count.
  - Go to WRITE when lane reaches BYTE_SIZE or the accepted count reaches LEN.
- WRITE (exactly one cycle):
  - Outputs: WE=1, DIN_READY=0, WA=BASE_ADDR+word_index*BYTE_SIZE, WD=buffer, BYTE_EN=filled lanes.
  - Unfilled lanes of WD are 0.
  - Next: clear buffer/lane, increment word_index. If count==LEN, go to FIN (BUSY=0, DONE=1); else return to COLLECT.
- Latency: a byte completing a word on edge n gives WE=1 in cycle n+1. Throughput is BYTE_SIZE bytes per BYTE_SIZE+1 cycles.
- Outside WRITE: WE=0. WA, WD and BYTE_EN hold their last values.
- DIN_VALID while DIN_READY=0 is not consumed; the source holds the byte.
- FIN: DONE and ERR hold until next START or RESET; CPU_HOLD=0.
- Word index never exceeds MEM_BYTES/BYTE_SIZE-1, guaranteed by the range check.

Test Plan:
1. Reset, START with BASE=0, LEN=8, stream 01..08 with VALID held high:
   - WE at cycles 5 and 10.
   - WA=0, WD=32'h04030201, BYTE_EN=4'hF, then WA=4, WD=32'h08070605.
   - DONE=1, BUSY=0 after.
2. BASE=4, LEN=6, bytes AA BB CC DD EE FF:
   - Writes WA=4 WD=32'hDDCCBBAA BE=F, then WA=8 WD=32'h0000FFEE BE=3.
3. Range/alignment errors, each giving ERR=1, DONE=1, no WE, DIN_READY never 1:
   - BASE=20, LEN=8.
   - BASE=2, LEN=4.
4. LEN=0 -> DONE=1 next cycle, ERR=0, no WE.
5. VALID toggled 1/0 every cycle, LEN=4:
   - Only handshaked bytes stored.
   - Single WE with correct word.
   - DIN_READY=0 during the WRITE cycle.
6. Mid-load: RESET asserted after 3 bytes -> next cycle all outputs 0, no WE. A second START then loads correctly from lane 0.
